// File: rtl/bus_drv_endpoint.sv
// Bus driver endpoint: host-side TX FIFO toward the bus and bus-side RX FIFO
// toward the host, both first-word-fall-through. RX packets can be filtered
// by destination ID. Sticky overflow flags and a saturating drop counter are
// cleared together by clr.
module bus_drv_endpoint #(
   parameter int unsigned pckg_sz   = 64,
   parameter int unsigned depth     = 16,
   parameter logic [7:0]  id        = 8'h00,
   parameter logic [7:0]  broadcast = 8'hFF,
   parameter int unsigned filter    = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [pckg_sz-1:0]           wr_data,
   output logic                         tx_full,
   output logic [$clog2(depth+1)-1:0]   tx_cnt,
   output logic                         pndng,
   output logic [pckg_sz-1:0]           D_pop,
   input  logic                         pop,
   input  logic                         push,
   input  logic [pckg_sz-1:0]           D_push,
   input  logic                         rd_en,
   output logic [pckg_sz-1:0]           rd_data,
   output logic                         rx_valid,
   output logic [$clog2(depth+1)-1:0]   rx_cnt,
   output logic                         tx_ovf,
   output logic                         rx_ovf,
   output logic [15:0]                  drop_cnt,
   input  logic                         clr
);

   localparam int unsigned CW = $clog2(depth + 1);
   localparam int unsigned PW = $clog2(depth);

   logic [pckg_sz-1:0] tx_mem [depth];
   logic [pckg_sz-1:0] rx_mem [depth];
   logic [PW-1:0]      tx_wp, tx_rp, rx_wp, rx_rp;
   logic               rx_full;
   logic               tx_wr_ok, tx_rd_ok, rx_wr_ok, rx_rd_ok;
   logic               rx_accept;
   logic [7:0]         rx_dst;

   assign pndng    = (tx_cnt != '0);
   assign tx_full  = (tx_cnt == CW'(depth));
   assign rx_valid = (rx_cnt != '0);
   assign rx_full  = (rx_cnt == CW'(depth));

   assign D_pop    = pndng    ? tx_mem[tx_rp] : '0;
   assign rd_data  = rx_valid ? rx_mem[rx_rp] : '0;

   assign rx_dst    = D_push[pckg_sz-1 -: 8];
   assign rx_accept = (filter == 0) || (rx_dst == id) || (rx_dst == broadcast);

   // A read on a full FIFO frees the slot the same-cycle write lands in.
   assign tx_rd_ok = pop && pndng;
   assign tx_wr_ok = wr_en && (!tx_full || tx_rd_ok);
   assign rx_rd_ok = rd_en && rx_valid;
   assign rx_wr_ok = push && rx_accept && (!rx_full || rx_rd_ok);

   // TX storage write; contents are only visible through the occupancy gate
   always_ff @(posedge clk) begin
      if (tx_wr_ok) tx_mem[tx_wp] <= wr_data;
   end

   // RX storage write; contents are only visible through the occupancy gate
   always_ff @(posedge clk) begin
      if (rx_wr_ok) rx_mem[rx_wp] <= D_push;
   end

   // TX pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_wr_ok) tx_wp <= tx_wp + PW'(1);
         if (tx_rd_ok) tx_rp <= tx_rp + PW'(1);
         if (tx_wr_ok && !tx_rd_ok)      tx_cnt <= tx_cnt + CW'(1);
         else if (!tx_wr_ok && tx_rd_ok) tx_cnt <= tx_cnt - CW'(1);
      end
   end

   // RX pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else begin
         if (rx_wr_ok) rx_wp <= rx_wp + PW'(1);
         if (rx_rd_ok) rx_rp <= rx_rp + PW'(1);
         if (rx_wr_ok && !rx_rd_ok)      rx_cnt <= rx_cnt + CW'(1);
         else if (!rx_wr_ok && rx_rd_ok) rx_cnt <= rx_cnt - CW'(1);
      end
   end

   // Sticky status: clr wins over any same-cycle set or increment
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_ovf   <= 1'b0;
         rx_ovf   <= 1'b0;
         drop_cnt <= '0;
      end else if (clr) begin
         tx_ovf   <= 1'b0;
         rx_ovf   <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (wr_en && tx_full && !pop)               tx_ovf <= 1'b1;
         if (push && rx_accept && rx_full && !rd_en) rx_ovf <= 1'b1;
         if (push && !rx_accept && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_bus_drv_endpoint.sv
// Directed bench for bus_drv_endpoint: a table of single-cycle vectors plus
// hand-written sequences for overflow, full-boundary, reset and wrap cases.
module tb_bus_drv_endpoint;

   localparam int unsigned PS = 64;
   localparam int unsigned DP = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en, pop, push, rd_en, clr;
   logic [PS-1:0] wr_data, D_push;
   logic          tx_full, pndng, rx_valid, tx_ovf, rx_ovf;
   logic [4:0]    tx_cnt, rx_cnt;
   logic [PS-1:0] D_pop, rd_data;
   logic [15:0]   drop_cnt;

   int unsigned nchk = 0;
   int unsigned nerr = 0;

   bus_drv_endpoint #(
      .pckg_sz(PS), .depth(DP), .id(8'h03), .broadcast(8'hFF), .filter(1)
   ) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx_cnt(tx_cnt),
      .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push), .rd_en(rd_en), .rd_data(rd_data),
      .rx_valid(rx_valid), .rx_cnt(rx_cnt),
      .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .drop_cnt(drop_cnt), .clr(clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic [PS-1:0] wd;
      logic          pp;
      logic          ps;
      logic [PS-1:0] dp;
      logic          rd;
      logic          cl;
      int unsigned   e_txcnt;
      logic [PS-1:0] e_dpop;
      logic          e_txovf;
      int unsigned   e_rxcnt;
      logic [PS-1:0] e_rd;
      logic          e_rxovf;
      int unsigned   e_drop;
   } vec_t;

   localparam logic [PS-1:0] A  = 64'h01A0_0000_0000_00A1;
   localparam logic [PS-1:0] B  = 64'h02B0_0000_0000_00B2;
   localparam logic [PS-1:0] C  = 64'h03C0_0000_0000_00C3;
   localparam logic [PS-1:0] D  = 64'h04D0_0000_0000_00D4;
   localparam logic [PS-1:0] P1 = 64'h0300_0000_0000_0011;
   localparam logic [PS-1:0] P2 = 64'hFF00_0000_0000_0022;
   localparam logic [PS-1:0] P3 = 64'h0500_0000_0000_0033;
   localparam logic [PS-1:0] P4 = 64'h0700_0000_0000_0044;

   vec_t vecs[15];

   function automatic vec_t mk(logic wr, logic [PS-1:0] wd, logic pp, logic ps,
                               logic [PS-1:0] dp, logic rd, logic cl,
                               int unsigned etc, logic [PS-1:0] edp, logic eto,
                               int unsigned erc, logic [PS-1:0] erd, logic ero,
                               int unsigned edr);
      vec_t v;
      v.wr = wr; v.wd = wd; v.pp = pp; v.ps = ps; v.dp = dp; v.rd = rd; v.cl = cl;
      v.e_txcnt = etc; v.e_dpop = edp; v.e_txovf = eto;
      v.e_rxcnt = erc; v.e_rd = erd; v.e_rxovf = ero; v.e_drop = edr;
      return v;
   endfunction

   function automatic logic [PS-1:0] txd(int unsigned i);
      return 64'hA500_0000_0000_0000 | 64'(i);
   endfunction

   function automatic logic [PS-1:0] rxd(int unsigned i);
      return 64'h0355_0000_0000_0000 | 64'(i);
   endfunction

   task automatic chk(input string nm, input logic [PS-1:0] act, input logic [PS-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_in();
      wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0; clr = 1'b0;
      wr_data = '0; D_push = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle_in();
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, ".pndng"},    64'(pndng),    '0);
      chk({nm, ".D_pop"},    D_pop,         '0);
      chk({nm, ".tx_full"},  64'(tx_full),  '0);
      chk({nm, ".tx_cnt"},   64'(tx_cnt),   '0);
      chk({nm, ".rx_valid"}, 64'(rx_valid), '0);
      chk({nm, ".rd_data"},  rd_data,       '0);
      chk({nm, ".rx_cnt"},   64'(rx_cnt),   '0);
      chk({nm, ".tx_ovf"},   64'(tx_ovf),   '0);
      chk({nm, ".rx_ovf"},   64'(rx_ovf),   '0);
      chk({nm, ".drop_cnt"}, 64'(drop_cnt), '0);
   endtask

   logic [PS-1:0] q[$];

   initial begin
      idle_in();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset = 1'b1;

      //            wr  wd  pop push dp   rd cl  txc dpop ovf rxc rd  rxo drop
      vecs[0]  = mk(0, '0, 0, 0, '0, 0, 0,  0, '0, 0,  0, '0, 0, 0);
      vecs[1]  = mk(1, A,  0, 0, '0, 0, 0,  1, A,  0,  0, '0, 0, 0);
      vecs[2]  = mk(1, B,  0, 0, '0, 0, 0,  2, A,  0,  0, '0, 0, 0);
      vecs[3]  = mk(1, C,  0, 1, P1, 0, 0,  3, A,  0,  1, P1, 0, 0);
      vecs[4]  = mk(0, '0, 1, 1, P2, 0, 0,  2, B,  0,  2, P1, 0, 0);
      vecs[5]  = mk(0, '0, 1, 1, P3, 0, 0,  1, C,  0,  2, P1, 0, 1);
      vecs[6]  = mk(0, '0, 1, 0, '0, 0, 0,  0, '0, 0,  2, P1, 0, 1);
      vecs[7]  = mk(1, D,  1, 0, '0, 0, 0,  1, D,  0,  2, P1, 0, 1);
      vecs[8]  = mk(0, '0, 0, 0, '0, 1, 0,  1, D,  0,  1, P2, 0, 1);
      vecs[9]  = mk(0, '0, 0, 1, P4, 0, 1,  1, D,  0,  1, P2, 0, 0);
      vecs[10] = mk(0, '0, 0, 0, '0, 1, 0,  1, D,  0,  0, '0, 0, 0);
      vecs[11] = mk(0, '0, 1, 0, '0, 1, 0,  0, '0, 0,  0, '0, 0, 0);
      vecs[12] = mk(0, '0, 1, 0, '0, 1, 0,  0, '0, 0,  0, '0, 0, 0);
      vecs[13] = mk(0, '0, 0, 1, P4, 0, 0,  0, '0, 0,  0, '0, 0, 1);
      vecs[14] = mk(0, '0, 0, 0, '0, 0, 1,  0, '0, 0,  0, '0, 0, 0);

      for (int i = 0; i < 15; i++) begin
         wr_en = vecs[i].wr; wr_data = vecs[i].wd; pop = vecs[i].pp;
         push = vecs[i].ps; D_push = vecs[i].dp; rd_en = vecs[i].rd; clr = vecs[i].cl;
         tick();
         chk($sformatf("v%0d.tx_cnt", i),   64'(tx_cnt),   64'(vecs[i].e_txcnt));
         chk($sformatf("v%0d.pndng", i),    64'(pndng),    64'(vecs[i].e_txcnt != 0));
         chk($sformatf("v%0d.D_pop", i),    D_pop,         vecs[i].e_dpop);
         chk($sformatf("v%0d.tx_ovf", i),   64'(tx_ovf),   64'(vecs[i].e_txovf));
         chk($sformatf("v%0d.rx_cnt", i),   64'(rx_cnt),   64'(vecs[i].e_rxcnt));
         chk($sformatf("v%0d.rx_valid", i), 64'(rx_valid), 64'(vecs[i].e_rxcnt != 0));
         chk($sformatf("v%0d.rd_data", i),  rd_data,       vecs[i].e_rd);
         chk($sformatf("v%0d.rx_ovf", i),   64'(rx_ovf),   64'(vecs[i].e_rxovf));
         chk($sformatf("v%0d.drop_cnt", i), 64'(drop_cnt), 64'(vecs[i].e_drop));
      end

      // TX overflow: 17 writes, the last one dropped
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = txd(i);
         tick();
      end
      chk("txfill.tx_full", 64'(tx_full), 64'(1));
      chk("txfill.tx_cnt",  64'(tx_cnt),  64'(16));
      chk("txfill.tx_ovf",  64'(tx_ovf),  64'(0));
      wr_en = 1'b1; wr_data = txd(16);
      tick();
      chk("txovf.tx_full", 64'(tx_full), 64'(1));
      chk("txovf.tx_cnt",  64'(tx_cnt),  64'(16));
      chk("txovf.tx_ovf",  64'(tx_ovf),  64'(1));
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("txovf.order%0d", i), D_pop, txd(i));
         pop = 1'b1;
         tick();
      end
      chk("txovf.drained", 64'(pndng), 64'(0));
      chk("txovf.dpop0",   D_pop,       '0);
      clr = 1'b1;
      tick();
      chk("txovf.clr", 64'(tx_ovf), 64'(0));

      // Full-boundary: write and pop together while full
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = txd(32 + i);
         tick();
      end
      wr_en = 1'b1; wr_data = txd(99); pop = 1'b1;
      tick();
      chk("txsim.tx_cnt",  64'(tx_cnt),  64'(16));
      chk("txsim.tx_full", 64'(tx_full), 64'(1));
      chk("txsim.tx_ovf",  64'(tx_ovf),  64'(0));
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("txsim.order%0d", i), D_pop, (i < 15) ? txd(33 + i) : txd(99));
         pop = 1'b1;
         tick();
      end
      chk("txsim.empty", 64'(tx_cnt), 64'(0));

      // RX overflow and full-boundary read/write
      for (int i = 0; i < 16; i++) begin
         push = 1'b1; D_push = rxd(i);
         tick();
      end
      push = 1'b1; D_push = rxd(16);
      tick();
      chk("rxovf.rx_cnt", 64'(rx_cnt), 64'(16));
      chk("rxovf.rx_ovf", 64'(rx_ovf), 64'(1));
      clr = 1'b1;
      tick();
      chk("rxovf.clr", 64'(rx_ovf), 64'(0));
      push = 1'b1; D_push = rxd(17); rd_en = 1'b1;
      tick();
      chk("rxsim.rx_cnt", 64'(rx_cnt), 64'(16));
      chk("rxsim.rx_ovf", 64'(rx_ovf), 64'(0));
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("rxsim.order%0d", i), rd_data, (i < 15) ? rxd(1 + i) : rxd(17));
         rd_en = 1'b1;
         tick();
      end
      chk("rxsim.empty", 64'(rx_valid), 64'(0));

      // Reset asserted in the middle of a pop cycle
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = txd(200 + i); push = 1'b1; D_push = rxd(200 + i);
         tick();
      end
      chk("prerst.tx_cnt", 64'(tx_cnt), 64'(5));
      chk("prerst.rx_cnt", 64'(rx_cnt), 64'(5));
      pop = 1'b1;
      #3 reset = 1'b0;
      #1;
      chk_all_zero("midrst");
      pop = 1'b0;
      #2 reset = 1'b1;
      tick();
      chk("postrst.tx_cnt", 64'(tx_cnt), 64'(0));
      wr_en = 1'b1; wr_data = txd(300);
      tick();
      chk("postrst.tx_cnt1", 64'(tx_cnt), 64'(1));
      chk("postrst.dpop",    D_pop,       txd(300));
      chk("postrst.rx_cnt",  64'(rx_cnt), 64'(0));

      // Wrap: random write/pop gaps against a queue model
      q.delete();
      q.push_back(txd(300));
      for (int c = 0; c < 40; c++) begin
         logic w, p, pok, wok;
         chk($sformatf("wrap.head%0d", c), D_pop, (q.size() != 0) ? q[0] : '0);
         chk($sformatf("wrap.cnt%0d", c), 64'(tx_cnt), 64'(q.size()));
         w = ($urandom_range(0, 2) != 0);
         p = ($urandom_range(0, 2) != 0);
         pok = p && (q.size() != 0);
         wok = w && ((q.size() < DP) || pok);
         wr_en = w; wr_data = txd(400 + c); pop = p;
         if (pok) void'(q.pop_front());
         if (wok) q.push_back(txd(400 + c));
         tick();
      end
      for (int i = 0; i < 17 && q.size() != 0; i++) begin
         chk($sformatf("wrapdrain.head%0d", i), D_pop, q[0]);
         void'(q.pop_front());
         pop = 1'b1;
         tick();
      end
      chk("wrap.empty",  64'(pndng),  64'(0));
      chk("wrap.tx_ovf", 64'(tx_ovf), 64'(0));
      chk("wrap.rx_ovf", 64'(rx_ovf), 64'(0));

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
